password_detector: RTL and testbench
====================================

PASSWORD_DETECTOR -- requirements
Module: password_detector

Interface
REQ-001 Parameter CODE_LEN, default 4: number of digits per code entry.
REQ-002 Parameter PASSWORD, default 8'hE4: stored code, 2 bits per digit; digit i = PASSWORD[2i+1:2i], digit 0 entered first.
REQ-003 Parameter TIMEOUT_COUNT, default 32'd500_000_000: idle cycles allowed between presses during entry.
REQ-004 Parameter UNLOCK_CYCLES, default 32'd200_000_000: unlock pulse length in cycles.
REQ-005 Parameter LOCK_CYCLES, default 32'd1000_000_000: lockout length in cycles.
REQ-006 Parameter MAX_FAIL, default 3: consecutive failed entries that trigger lockout.
REQ-007 clk  input  1  system clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 btn_in  input  4  debounced button levels; bit k pressed = digit value k.
REQ-010 unlock  output  1  high while code accepted (UNLOCKED state).
REQ-011 error  output  1  one-cycle pulse on a rejected entry that does not cause lockout.
REQ-012 alarm  output  1  high while in LOCKOUT.
REQ-013 digit_count  output  3  digits entered in the current attempt.
REQ-014 fail_count  output  2  consecutive failed attempts.

Function
REQ-015 Block SHALL register btn_in into btn_q each cycle; rise = btn_in & ~btn_q.
REQ-016 A valid press SHALL be a cycle where rise is one-hot; rise with 2+ bits set SHALL be an invalid press.
REQ-017 States SHALL be IDLE, ENTRY, CHECK, UNLOCKED, FAIL, LOCKOUT; all outputs registered (Moore).
REQ-018 IDLE: digit_count=0, timer=0; any press (valid or invalid) -> ENTRY, digit_count=1, mismatch flag set if press invalid or value != digit 0.
REQ-019 ENTRY: each press increments digit_count, ORs mismatch with (invalid or value != digit[digit_count]), clears timer.
REQ-020 ENTRY: when press makes digit_count == CODE_LEN -> CHECK on the same edge.
REQ-021 ENTRY: no press for TIMEOUT_COUNT consecutive cycles -> IDLE; attempt abandoned, fail_count unchanged, no error pulse.
REQ-022 CHECK (exactly one cycle): mismatch=0 -> UNLOCKED, fail_count=0; mismatch=1 and fail_count+1 == MAX_FAIL -> LOCKOUT; otherwise -> FAIL, fail_count+1.
REQ-023 Latency: unlock/alarm/error SHALL assert 2 rising edges after the edge sampling the last digit's press.
REQ-024 FAIL: error=1 for one cycle, then IDLE.
REQ-025 UNLOCKED: unlock=1 for exactly UNLOCK_CYCLES cycles, then IDLE; presses ignored.
REQ-026 LOCKOUT: alarm=1 for exactly LOCK_CYCLES cycles, presses ignored; exit -> IDLE with fail_count=0.
REQ-027 A button held across a state exit SHALL NOT create a press; only a new rising edge counts.
REQ-028 Timers SHALL be 32-bit, cleared on every state entry; no wrap-around reachable.
REQ-029 mismatch SHALL clear on entry to IDLE.

Reset
REQ-030 On reset: state=IDLE, btn_q=4'b0000, unlock=0, error=0, alarm=0, digit_count=0, fail_count=0, timers=0, mismatch=0.
REQ-031 Reset mid-entry, mid-UNLOCKED or mid-LOCKOUT SHALL abort immediately to reset values, including clearing fail_count.
REQ-032 A button held high through reset release SHALL register as a press on the first edge after release (btn_q=0).

Verification (PASSWORD=8'hE4, CODE_LEN=4, TIMEOUT_COUNT=100, UNLOCK_CYCLES=20, LOCK_CYCLES=50, MAX_FAIL=3)
REQ-033 Presses 0,1,2,3 (btn_in 0001,0010,0100,1000, gaps 5 cycles) -> unlock high 20 cycles, 2 edges after last press; fail_count=0.
REQ-034 Presses 0,1,3,3 -> error one-cycle pulse, fail_count=1, unlock stays 0.
REQ-035 Three wrong entries in a row -> errors after 1st and 2nd, alarm high 50 cycles after 3rd, presses during alarm ignored, then fail_count=0.
REQ-036 Presses 0,1 then 100 idle cycles -> IDLE, digit_count=0, no error, fail_count unchanged; then 0,1,2,3 -> unlock.
REQ-037 btn_in 0011 rising together as first press, then 1,2,3 -> error (invalid press counts as wrong digit).
REQ-038 Reset asserted after 3 of 4 correct digits -> all outputs 0; subsequent 0,1,2,3 -> unlock.

Source files
------------

// File: rtl/password_detector.sv
// rtl/password_detector.sv - keypad code-entry lock with attempt timeout, unlock pulse and lockout.
// Outputs are registered from the state, so they follow the state by one cycle.
module password_detector #(
  parameter int                    CODE_LEN      = 4,
  parameter logic [2*CODE_LEN-1:0] PASSWORD      = 8'hE4,
  parameter logic [31:0]           TIMEOUT_COUNT = 32'd500_000_000,
  parameter logic [31:0]           UNLOCK_CYCLES = 32'd200_000_000,
  parameter logic [31:0]           LOCK_CYCLES   = 32'd1000_000_000,
  parameter int                    MAX_FAIL      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_in,
  output logic       unlock,
  output logic       error,
  output logic       alarm,
  output logic [2:0] digit_count,
  output logic [1:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_FAIL, S_LOCKOUT
  } state_t;

  state_t      state_q;
  logic [3:0]  btn_q;
  logic [31:0] timer_q;
  logic [2:0]  digit_count_q;
  logic [1:0]  fail_count_q;
  logic        mismatch_q;
  logic        unlock_q, error_q, alarm_q;

  logic [3:0]            rise;
  logic                  press;
  logic                  digit_bad;
  logic                  last_digit;
  logic                  fail_limit;
  logic [1:0]            press_val;
  logic [2*CODE_LEN-1:0] pw_shift;

  always_comb begin
    rise      = btn_in & ~btn_q;
    press     = |rise;
    press_val = 2'd0;
    case (rise)
      4'b0010: press_val = 2'd1;
      4'b0100: press_val = 2'd2;
      4'b1000: press_val = 2'd3;
      default: press_val = 2'd0;
    endcase
    // Expected digit for the press about to be counted; IDLE always has digit_count 0.
    pw_shift   = PASSWORD >> (2 * int'(digit_count_q));
    digit_bad  = !$onehot(rise) || (press_val != pw_shift[1:0]);
    last_digit = (int'(digit_count_q) + 1) == CODE_LEN;
    fail_limit = (int'(fail_count_q) + 1) == MAX_FAIL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      btn_q         <= 4'b0000;
      timer_q       <= 32'd0;
      digit_count_q <= 3'd0;
      fail_count_q  <= 2'd0;
      mismatch_q    <= 1'b0;
      unlock_q      <= 1'b0;
      error_q       <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      btn_q    <= btn_in;
      unlock_q <= (state_q == S_UNLOCKED);
      error_q  <= (state_q == S_FAIL);
      alarm_q  <= (state_q == S_LOCKOUT);
      case (state_q)
        S_IDLE: begin
          timer_q       <= 32'd0;
          digit_count_q <= 3'd0;
          mismatch_q    <= 1'b0;
          if (press) begin
            digit_count_q <= 3'd1;
            mismatch_q    <= digit_bad;
            state_q       <= (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (press) begin
            digit_count_q <= digit_count_q + 3'd1;
            mismatch_q    <= mismatch_q | digit_bad;
            timer_q       <= 32'd0;
            if (last_digit) state_q <= S_CHECK;
          end else if (timer_q == TIMEOUT_COUNT - 32'd1) begin
            // Abandoned attempt: not counted as a failure.
            state_q       <= S_IDLE;
            timer_q       <= 32'd0;
            digit_count_q <= 3'd0;
            mismatch_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_CHECK: begin
          timer_q <= 32'd0;
          if (!mismatch_q) begin
            state_q      <= S_UNLOCKED;
            fail_count_q <= 2'd0;
          end else begin
            fail_count_q <= fail_count_q + 2'd1;
            state_q      <= fail_limit ? S_LOCKOUT : S_FAIL;
          end
        end
        S_UNLOCKED: begin
          if (timer_q == UNLOCK_CYCLES - 32'd1) begin
            state_q       <= S_IDLE;
            timer_q       <= 32'd0;
            digit_count_q <= 3'd0;
            mismatch_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_FAIL: begin
          state_q       <= S_IDLE;
          timer_q       <= 32'd0;
          digit_count_q <= 3'd0;
          mismatch_q    <= 1'b0;
        end
        S_LOCKOUT: begin
          if (timer_q == LOCK_CYCLES - 32'd1) begin
            state_q       <= S_IDLE;
            timer_q       <= 32'd0;
            digit_count_q <= 3'd0;
            mismatch_q    <= 1'b0;
            fail_count_q  <= 2'd0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unlock      = unlock_q;
  assign error       = error_q;
  assign alarm       = alarm_q;
  assign digit_count = digit_count_q;
  assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_password_detector.sv
// tb/tb_password_detector.sv - directed and randomized code entries checked against a reference model.
module tb_password_detector;

  localparam int          CODE_LEN = 4;
  localparam logic [7:0]  PW       = 8'hE4;
  localparam int          TIMEOUT  = 100;
  localparam int          UNL      = 20;
  localparam int          LCK      = 50;
  localparam int          MAXF     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_in = 4'b0000;
  logic       unlock, error, alarm;
  logic [2:0] digit_count;
  logic [1:0] fail_count;

  int checks = 0;
  int fails = 0;
  int model_fail = 0;

  password_detector #(
    .CODE_LEN(CODE_LEN), .PASSWORD(PW), .TIMEOUT_COUNT(32'(TIMEOUT)),
    .UNLOCK_CYCLES(32'(UNL)), .LOCK_CYCLES(32'(LCK)), .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .unlock(unlock), .error(error),
    .alarm(alarm), .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Button pattern that enters digit i of the stored code.
  function automatic logic [3:0] good_pat(input int i);
    int d;
    d = (int'(PW) >> (2 * i)) % 4;
    return 4'(1 << d);
  endfunction

  task automatic press(input logic [3:0] p);
    btn_in = p;
    tick;
    btn_in = 4'b0000;
  endtask

  // kind: 0 unlock, 1 error, 2 lockout. Called at the negedge right after the last press edge.
  task automatic expect_result(input int kind);
    int n;
    tick;
    chk("latency_unlock", 32'(unlock), 0);
    chk("latency_error", 32'(error), 0);
    chk("latency_alarm", 32'(alarm), 0);
    tick;
    n = 0;
    case (kind)
      0: begin
        while (unlock === 1'b1 && n < 200) begin n++; tick; end
        chk("unlock_len", n, UNL);
        chk("fail_after_unlock", 32'(fail_count), 0);
      end
      1: begin
        chk("error_pulse", 32'(error), 1);
        chk("unlock_on_error", 32'(unlock), 0);
        chk("fail_count_err", 32'(fail_count), 32'(model_fail));
        tick;
        chk("error_width", 32'(error), 0);
      end
      default: begin
        while (alarm === 1'b1 && n < 200) begin
          btn_in = (n < 40) ? 4'($urandom) : 4'b0000;
          n++;
          tick;
        end
        btn_in = 4'b0000;
        chk("alarm_len", n, LCK);
        chk("fail_after_lock", 32'(fail_count), 0);
        chk("dc_after_lock", 32'(digit_count), 0);
      end
    endcase
  endtask

  // pats holds four button patterns, digit 0 in the low nibble; gap 0 means random gaps.
  task automatic do_attempt(input logic [15:0] pats, input int gap);
    int kind;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < CODE_LEN; i++) begin
      press(pats[4*i +: 4]);
      chk("digit_count", 32'(digit_count), 32'(i + 1));
      if (pats[4*i +: 4] !== good_pat(i)) ok = 1'b0;
      if (i < CODE_LEN - 1) repeat ((gap == 0) ? $urandom_range(1, 6) : gap) tick;
    end
    if (ok) begin
      kind = 0; model_fail = 0;
    end else if (model_fail + 1 == MAXF) begin
      kind = 2; model_fail = 0;
    end else begin
      kind = 1; model_fail++;
    end
    expect_result(kind);
    repeat (2) tick;
  endtask

  initial begin
    logic [15:0] pats;
    bit          err_seen;
    int          r;

    @(negedge clk);
    tick;
    chk("rst_unlock", 32'(unlock), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_dc", 32'(digit_count), 0);
    chk("rst_fail", 32'(fail_count), 0);
    reset = 1'b0;
    repeat (2) tick;

    do_attempt({4'b1000, 4'b0100, 4'b0010, 4'b0001}, 5);
    do_attempt({4'b1000, 4'b1000, 4'b0010, 4'b0001}, 5);

    // Abandoned attempt: digits 0,1 then silence until timeout.
    press(4'b0001);
    tick;
    press(4'b0010);
    err_seen = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick;
      err_seen |= error;
    end
    chk("dc_before_timeout", 32'(digit_count), 2);
    tick;
    err_seen |= error;
    chk("dc_after_timeout", 32'(digit_count), 0);
    chk("no_error_timeout", 32'(err_seen), 0);
    chk("fail_kept_timeout", 32'(fail_count), 32'(model_fail));
    tick;
    do_attempt({4'b1000, 4'b0100, 4'b0010, 4'b0001}, 3);

    // Two buttons rising together count as a wrong digit.
    do_attempt({4'b1000, 4'b0100, 4'b0010, 4'b0011}, 4);

    // Reset clears the failure count.
    reset = 1'b1;
    #1;
    chk("rst_clears_fail", 32'(fail_count), 0);
    model_fail = 0;
    tick;
    reset = 1'b0;
    repeat (2) tick;

    do_attempt({4'b0001, 4'b0001, 4'b0001, 4'b0001}, 2);
    do_attempt({4'b0010, 4'b0100, 4'b1000, 4'b0001}, 2);
    do_attempt({4'b0100, 4'b0100, 4'b0100, 4'b0100}, 2);

    // Reset after three correct digits, with digit 0 held through release.
    press(4'b0001); tick;
    press(4'b0010); tick;
    press(4'b0100);
    chk("dc_three", 32'(digit_count), 3);
    tick;
    btn_in = 4'b0001;
    reset = 1'b1;
    #1;
    chk("midrst_unlock", 32'(unlock), 0);
    chk("midrst_error", 32'(error), 0);
    chk("midrst_alarm", 32'(alarm), 0);
    chk("midrst_dc", 32'(digit_count), 0);
    chk("midrst_fail", 32'(fail_count), 0);
    model_fail = 0;
    tick;
    @(negedge clk);
    reset = 1'b0;
    tick;
    btn_in = 4'b0000;
    chk("held_through_reset", 32'(digit_count), 1);
    tick;
    press(4'b0010); tick;
    press(4'b0100); tick;
    press(4'b1000);
    expect_result(0);
    repeat (2) tick;

    for (int a = 0; a < 20; a++) begin
      bit aim;
      aim = 1'($urandom_range(0, 1));
      for (int i = 0; i < CODE_LEN; i++) begin
        r = $urandom_range(0, 9);
        if (aim || r < 4) pats[4*i +: 4] = good_pat(i);
        else if (r < 8) pats[4*i +: 4] = 4'(1 << $urandom_range(0, 3));
        else pats[4*i +: 4] = 4'($urandom_range(1, 15));
      end
      do_attempt(pats, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
